// File: rtl/control_pkg.sv
// ---------------------------------------------------------------------------
// control_pkg
// Shared constants for the multicycle control unit: state encodings, opcode
// and extension values, branch/jump condition codes, processor-status flag
// positions, datapath mux select codes and the bundled control-word type.
// Also provides the sign-extension select helper used by the top level.
// ---------------------------------------------------------------------------
package control_pkg;

   // State encodings (also visible externally on state_dbg)
   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_FETCH2  = 4'd1;
   localparam logic [3:0] S_DECODE  = 4'd2;
   localparam logic [3:0] S_EXEC    = 4'd3;
   localparam logic [3:0] S_ALU_WB  = 4'd4;
   localparam logic [3:0] S_MOV     = 4'd5;
   localparam logic [3:0] S_MOVI    = 4'd6;
   localparam logic [3:0] S_LD_ADDR = 4'd7;
   localparam logic [3:0] S_LD_CAP  = 4'd8;
   localparam logic [3:0] S_LD_WB   = 4'd9;
   localparam logic [3:0] S_STORE   = 4'd10;
   localparam logic [3:0] S_BRANCH  = 4'd11;
   localparam logic [3:0] S_JUMP    = 4'd12;

   // Primary opcodes
   localparam logic [3:0] OP_RTYPE   = 4'b0000;
   localparam logic [3:0] OP_ANDI    = 4'b0001;
   localparam logic [3:0] OP_ORI     = 4'b0010;
   localparam logic [3:0] OP_XORI    = 4'b0011;
   localparam logic [3:0] OP_SPECIAL = 4'b0100;
   localparam logic [3:0] OP_CMPI    = 4'b1011;
   localparam logic [3:0] OP_BCOND   = 4'b1100;
   localparam logic [3:0] OP_MOVI    = 4'b1101;
   localparam logic [3:0] OP_NOP     = 4'b1111;

   // Opcode extensions
   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;
   localparam logic [3:0] EXT_CMP   = 4'b1011;
   localparam logic [3:0] EXT_JCOND = 4'b1100;
   localparam logic [3:0] EXT_MOV   = 4'b1101;

   // Condition codes carried in the Rdest field of branches and jumps
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_GT = 4'b0110;
   localparam logic [3:0] COND_LE = 4'b0111;
   localparam logic [3:0] COND_LT = 4'b1100;
   localparam logic [3:0] COND_GE = 4'b1101;
   localparam logic [3:0] COND_UC = 4'b1110;

   // Bit positions inside PSR_OUT
   localparam int FLAG_C = 0;
   localparam int FLAG_L = 1;
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 4;

   // Datapath mux select codes
   localparam logic [1:0] WD_IMM     = 2'b00;
   localparam logic [1:0] WD_RSRC    = 2'b01;
   localparam logic [1:0] WD_MEM     = 2'b10;
   localparam logic [1:0] WD_ALU     = 2'b11;
   localparam logic [1:0] ALUA_RSRC  = 2'b00;
   localparam logic [1:0] ALUA_PC    = 2'b01;
   localparam logic [1:0] ALUA_IMM   = 2'b10;
   localparam logic [1:0] ALUB_RDEST = 2'b00;
   localparam logic [1:0] ALUB_IMM   = 2'b01;
   localparam logic [1:0] ALUB_ONE   = 2'b10;

   // One control word, decoded from the current state each cycle
   typedef struct packed {
      logic       pcS;
      logic       memS;
      logic [1:0] wdS;
      logic [1:0] aluaS;
      logic [1:0] alubS;
      logic       instrEn;
      logic       aluOutEn;
      logic       memRegEn;
      logic       pcEn;
      logic       psrEn;
      logic       regWr;
      logic       memWe;
   } ctrl_t;

   // Logical immediates and MOVI take a zero-extended immediate; everything
   // else (arithmetic immediates, branch displacements) is sign-extended.
   function automatic logic seSignFor(input logic [3:0] op);
      logic zeroExt;
      zeroExt = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_MOVI);
      return !zeroExt;
   endfunction

endpackage

// File: rtl/cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational branch/jump condition evaluator.
//   cond_i  : condition code taken from the Rdest field
//   flags_i : processor status flags {N, Z, F, L, C}
//   taken_o : 1 when the condition holds; unknown codes are never taken
// ---------------------------------------------------------------------------
module cond_eval
   import control_pkg::*;
#(
   parameter int OPL  = 4,
   parameter int PSRL = 5
) (
   input  logic [OPL-1:0]  cond_i,
   input  logic [PSRL-1:0] flags_i,
   output logic            taken_o
);

   // Map each condition code onto a single flag or its complement
   always_comb begin
      taken_o = 1'b0;
      case (cond_i)
         COND_EQ: taken_o =  flags_i[FLAG_Z];
         COND_NE: taken_o = !flags_i[FLAG_Z];
         COND_CS: taken_o =  flags_i[FLAG_C];
         COND_CC: taken_o = !flags_i[FLAG_C];
         COND_GT: taken_o =  flags_i[FLAG_N];
         COND_LE: taken_o = !flags_i[FLAG_N];
         COND_LT: taken_o =  flags_i[FLAG_L];
         COND_GE: taken_o = !flags_i[FLAG_L];
         COND_UC: taken_o = 1'b1;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// ---------------------------------------------------------------------------
// control_fsm
// Moore-style multicycle control unit. Every datapath control is decoded
// from the current state, apart from SE_SIGN (follows OP_CODE) and the
// taken term that gates the PC update in BRANCH/JUMP.
//   clk, reset            : clock (rising edge), async active-low reset
//   OP_CODE, OP_EXT       : instruction opcode and extension fields
//   Rdest_addr            : destination field, also the condition code
//   PSR_OUT               : status flags {N, Z, F, L, C}
//   PC_S, MEM_S           : PC source / memory address source selects
//   WD_S, ALUA_S, ALUB_S  : write-data and ALU operand selects
//   INSTR_EN .. MEM_WE    : register enables, regfile and memory writes
//   SE_SIGN               : immediate sign-extension select
//   state_dbg             : current state encoding
// ---------------------------------------------------------------------------
module control_fsm
   import control_pkg::*;
#(
   parameter int OPL  = 4,
   parameter int PSRL = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [OPL-1:0]  OP_CODE,
   input  logic [OPL-1:0]  OP_EXT,
   input  logic [OPL-1:0]  Rdest_addr,
   input  logic [PSRL-1:0] PSR_OUT,
   output logic            PC_S,
   output logic            MEM_S,
   output logic [1:0]      WD_S,
   output logic [1:0]      ALUA_S,
   output logic [1:0]      ALUB_S,
   output logic            INSTR_EN,
   output logic            ALU_OUT_EN,
   output logic            MEM_REG_EN,
   output logic            PC_EN,
   output logic            PSR_EN,
   output logic            SE_SIGN,
   output logic            REG_WR,
   output logic            MEM_WE,
   output logic [3:0]      state_dbg
);

   logic [3:0] stateQ, stateD;
   // Instruction class captured in DECODE so EXEC depends on state only
   logic       immQ, immD;
   logic       cmpQ, cmpD;
   logic       taken;
   ctrl_t      ctrl;

   cond_eval #(.OPL(OPL), .PSRL(PSRL)) uCondEval (
      .cond_i  (Rdest_addr),
      .flags_i (PSR_OUT),
      .taken_o (taken)
   );

   // State register; reset lands in FETCH so a new fetch begins on release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ <= S_FETCH;
         immQ   <= 1'b0;
         cmpQ   <= 1'b0;
      end else begin
         stateQ <= stateD;
         immQ   <= immD;
         cmpQ   <= cmpD;
      end
   end

   // Next-state logic; DECODE dispatches on opcode/extension and records
   // whether EXEC must use the immediate operand and whether it is a compare
   always_comb begin
      stateD = S_FETCH;
      immD   = immQ;
      cmpD   = cmpQ;
      case (stateQ)
         S_FETCH:  stateD = S_FETCH2;
         S_FETCH2: stateD = S_DECODE;
         S_DECODE: begin
            immD = (OP_CODE != OP_RTYPE);
            cmpD = ((OP_CODE == OP_RTYPE) && (OP_EXT == EXT_CMP)) || (OP_CODE == OP_CMPI);
            case (OP_CODE)
               OP_RTYPE:   stateD = (OP_EXT == EXT_MOV) ? S_MOV : S_EXEC;
               OP_SPECIAL: begin
                  case (OP_EXT)
                     EXT_LOAD:  stateD = S_LD_ADDR;
                     EXT_STOR:  stateD = S_STORE;
                     EXT_JCOND: stateD = S_JUMP;
                     default:   stateD = S_FETCH;
                  endcase
               end
               OP_BCOND: stateD = S_BRANCH;
               OP_MOVI:  stateD = S_MOVI;
               OP_NOP:   stateD = S_FETCH;
               default:  stateD = S_EXEC;
            endcase
         end
         S_EXEC:    stateD = cmpQ ? S_FETCH : S_ALU_WB;
         S_LD_ADDR: stateD = S_LD_CAP;
         S_LD_CAP:  stateD = S_LD_WB;
         default:   stateD = S_FETCH;
      endcase
   end

   // Output decode; PC_EN is only raised in states that never touch the
   // PSR, ALU output register or register file, so the datapath may force
   // the ALU to ADD whenever the PC is being updated
   always_comb begin
      ctrl = '0;
      case (stateQ)
         S_FETCH: ctrl.memS = 1'b1;
         S_FETCH2: begin
            ctrl.memS    = 1'b1;
            ctrl.instrEn = 1'b1;
            ctrl.pcEn    = 1'b1;
            ctrl.pcS     = 1'b1;
            ctrl.aluaS   = ALUA_PC;
            ctrl.alubS   = ALUB_ONE;
         end
         S_EXEC: begin
            ctrl.aluOutEn = 1'b1;
            ctrl.psrEn    = 1'b1;
            ctrl.aluaS    = immQ ? ALUA_IMM : ALUA_RSRC;
            ctrl.alubS    = ALUB_RDEST;
         end
         S_ALU_WB: begin
            ctrl.wdS   = WD_ALU;
            ctrl.regWr = 1'b1;
         end
         S_MOV: begin
            ctrl.wdS   = WD_RSRC;
            ctrl.regWr = 1'b1;
         end
         S_MOVI: begin
            ctrl.wdS   = WD_IMM;
            ctrl.regWr = 1'b1;
         end
         S_LD_CAP: ctrl.memRegEn = 1'b1;
         S_LD_WB: begin
            ctrl.wdS   = WD_MEM;
            ctrl.regWr = 1'b1;
         end
         S_STORE: ctrl.memWe = 1'b1;
         S_BRANCH: begin
            if (taken) begin
               ctrl.pcEn  = 1'b1;
               ctrl.pcS   = 1'b1;
               ctrl.aluaS = ALUA_PC;
               ctrl.alubS = ALUB_IMM;
            end
         end
         S_JUMP: begin
            if (taken) begin
               ctrl.pcEn = 1'b1;
               ctrl.pcS  = 1'b0;
            end
         end
         default: ctrl = '0;
      endcase
   end

   assign PC_S       = ctrl.pcS;
   assign MEM_S      = ctrl.memS;
   assign WD_S       = ctrl.wdS;
   assign ALUA_S     = ctrl.aluaS;
   assign ALUB_S     = ctrl.alubS;
   assign INSTR_EN   = ctrl.instrEn;
   assign ALU_OUT_EN = ctrl.aluOutEn;
   assign MEM_REG_EN = ctrl.memRegEn;
   assign PC_EN      = ctrl.pcEn;
   assign PSR_EN     = ctrl.psrEn;
   assign REG_WR     = ctrl.regWr;
   assign MEM_WE     = ctrl.memWe;
   assign SE_SIGN    = seSignFor(OP_CODE);
   assign state_dbg  = stateQ;

endmodule

// File: tb/tb_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_control_fsm
// Directed bench for control_fsm: each instruction is walked cycle by cycle,
// the expected state and control word for that cycle are queued, then popped
// and compared against the DUT half a cycle after the clock edge.
// ---------------------------------------------------------------------------
module tb_control_fsm;
   import control_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] OP_CODE, OP_EXT, Rdest_addr;
   logic [4:0] PSR_OUT;
   logic       PC_S, MEM_S;
   logic [1:0] WD_S, ALUA_S, ALUB_S;
   logic       INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN, SE_SIGN, REG_WR, MEM_WE;
   logic [3:0] state_dbg;

   typedef struct {
      string       tag;
      logic [18:0] val;
   } sbEntry_t;

   sbEntry_t sbQ[$];
   int       compared    = 0;
   int       mismatched  = 0;
   int       memWeCycles = 0;
   logic     regWrSeen   = 1'b0;

   control_fsm #(.OPL(4), .PSRL(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .OP_CODE    (OP_CODE),
      .OP_EXT     (OP_EXT),
      .Rdest_addr (Rdest_addr),
      .PSR_OUT    (PSR_OUT),
      .PC_S       (PC_S),
      .MEM_S      (MEM_S),
      .WD_S       (WD_S),
      .ALUA_S     (ALUA_S),
      .ALUB_S     (ALUB_S),
      .INSTR_EN   (INSTR_EN),
      .ALU_OUT_EN (ALU_OUT_EN),
      .MEM_REG_EN (MEM_REG_EN),
      .PC_EN      (PC_EN),
      .PSR_EN     (PSR_EN),
      .SE_SIGN    (SE_SIGN),
      .REG_WR     (REG_WR),
      .MEM_WE     (MEM_WE),
      .state_dbg  (state_dbg)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=no-finish expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected control word per state, written from the state table
   function automatic logic [14:0] expOuts(input logic [3:0] st, input logic [3:0] op, input logic tk);
      logic       pcS, memS, instrEn, aluOutEn, memRegEn, pcEn, psrEn, regWr, memWe;
      logic [1:0] wdS, aluaS, alubS;
      {pcS, memS, instrEn, aluOutEn, memRegEn, pcEn, psrEn, regWr, memWe} = '0;
      {wdS, aluaS, alubS} = '0;
      case (st)
         S_FETCH:   memS = 1'b1;
         S_FETCH2:  begin memS = 1'b1; instrEn = 1'b1; pcEn = 1'b1; pcS = 1'b1; aluaS = 2'b01; alubS = 2'b10; end
         S_EXEC:    begin aluOutEn = 1'b1; psrEn = 1'b1; aluaS = (op == 4'b0000) ? 2'b00 : 2'b10; alubS = 2'b00; end
         S_ALU_WB:  begin wdS = 2'b11; regWr = 1'b1; end
         S_MOV:     begin wdS = 2'b01; regWr = 1'b1; end
         S_MOVI:    begin wdS = 2'b00; regWr = 1'b1; end
         S_LD_CAP:  memRegEn = 1'b1;
         S_LD_WB:   begin wdS = 2'b10; regWr = 1'b1; end
         S_STORE:   memWe = 1'b1;
         S_BRANCH:  if (tk) begin pcEn = 1'b1; pcS = 1'b1; aluaS = 2'b01; alubS = 2'b01; end
         S_JUMP:    if (tk) pcEn = 1'b1;
         default:   ;
      endcase
      return {pcS, memS, wdS, aluaS, alubS, instrEn, aluOutEn, memRegEn, pcEn, psrEn, regWr, memWe};
   endfunction

   function automatic logic [18:0] obsVec();
      return {state_dbg, PC_S, MEM_S, WD_S, ALUA_S, ALUB_S,
              INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN, REG_WR, MEM_WE};
   endfunction

   // Per-cycle invariants: no memory write alongside a register write, and
   // no PC update alongside any ALU-result consumer
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (REG_WR) regWrSeen = 1'b1;
         if (MEM_WE) memWeCycles++;
         compared++;
         assert (!(MEM_WE && REG_WR) && !(PC_EN && (PSR_EN || ALU_OUT_EN || REG_WR))) else begin
            mismatched++;
            $error("[TB] FAIL exclusive-enables: observed=%b expected=no-overlap", obsVec());
         end
      end
   end

   // Pop the oldest expectation and compare it with the DUT right now
   task automatic checkOutput();
      sbEntry_t e;
      logic [18:0] obs;
      compared++;
      assert (sbQ.size() > 0) else begin
         mismatched++;
         $error("[TB] FAIL scoreboard-empty: observed=0 expected=entry");
      end
      if (sbQ.size() > 0) begin
         e   = sbQ.pop_front();
         obs = obsVec();
         assert (obs === e.val) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   // Drive one instruction from its FETCH cycle onward, queuing the expected
   // state/outputs for each cycle before sampling it
   task automatic applyStimulus(input string name, input logic [3:0] op, input logic [3:0] ext,
                                input logic [3:0] cond, input logic [4:0] psr, input logic expSe,
                                input logic tk, input int n, input logic [23:0] seq);
      logic [3:0] st;
      sbEntry_t   e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) begin
            OP_CODE = op; OP_EXT = ext; Rdest_addr = cond; PSR_OUT = psr;
            #1;
            compared++;
            assert (SE_SIGN === expSe) else begin
               mismatched++;
               $error("[TB] FAIL %s.se: observed=%b expected=%b", name, SE_SIGN, expSe);
            end
         end
         st    = seq[23 - 4*i -: 4];
         e.tag = $sformatf("%s.c%0d", name, i + 1);
         e.val = {st, expOuts(st, op, tk)};
         sbQ.push_back(e);
         checkOutput();
      end
   endtask

   // Directed sequence
   initial begin
      sbEntry_t e;
      reset = 1'b0; OP_CODE = 4'hF; OP_EXT = 4'h0; Rdest_addr = 4'h0; PSR_OUT = 5'b0;
      #1;
      e.tag = "reset.async"; e.val = {S_FETCH, expOuts(S_FETCH, 4'h0, 1'b0)};
      sbQ.push_back(e);
      checkOutput();
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;

      applyStimulus("add",    4'b0000, 4'b0101, 4'h1, 5'b00000, 1'b1, 1'b0, 5,
                    {S_FETCH, S_FETCH2, S_DECODE, S_EXEC, S_ALU_WB, 4'h0});
      applyStimulus("load",   4'b0100, 4'b0000, 4'h3, 5'b00000, 1'b1, 1'b0, 6,
                    {S_FETCH, S_FETCH2, S_DECODE, S_LD_ADDR, S_LD_CAP, S_LD_WB});
      applyStimulus("beqT",   4'b1100, 4'b0100, 4'h0, 5'b01000, 1'b1, 1'b1, 4,
                    {S_FETCH, S_FETCH2, S_DECODE, S_BRANCH, 8'h0});
      applyStimulus("beqN",   4'b1100, 4'b0100, 4'h0, 5'b00000, 1'b1, 1'b0, 4,
                    {S_FETCH, S_FETCH2, S_DECODE, S_BRANCH, 8'h0});
      applyStimulus("cmpi",   4'b1011, 4'b0011, 4'h2, 5'b00000, 1'b1, 1'b0, 4,
                    {S_FETCH, S_FETCH2, S_DECODE, S_EXEC, 8'h0});
      memWeCycles = 0;
      applyStimulus("store",  4'b0100, 4'b0100, 4'h2, 5'b00000, 1'b1, 1'b0, 4,
                    {S_FETCH, S_FETCH2, S_DECODE, S_STORE, 8'h0});
      applyStimulus("mov",    4'b0000, 4'b1101, 4'h5, 5'b00000, 1'b1, 1'b0, 4,
                    {S_FETCH, S_FETCH2, S_DECODE, S_MOV, 8'h0});
      compared++;
      assert (memWeCycles == 1) else begin
         mismatched++;
         $error("[TB] FAIL store.wecount: observed=%0d expected=1", memWeCycles);
      end
      applyStimulus("movi",   4'b1101, 4'b0111, 4'h6, 5'b00000, 1'b0, 1'b0, 4,
                    {S_FETCH, S_FETCH2, S_DECODE, S_MOVI, 8'h0});
      applyStimulus("andi",   4'b0001, 4'b1111, 4'h7, 5'b00000, 1'b0, 1'b0, 5,
                    {S_FETCH, S_FETCH2, S_DECODE, S_EXEC, S_ALU_WB, 4'h0});
      applyStimulus("cmp",    4'b0000, 4'b1011, 4'h1, 5'b00000, 1'b1, 1'b0, 4,
                    {S_FETCH, S_FETCH2, S_DECODE, S_EXEC, 8'h0});
      applyStimulus("juc",    4'b0100, 4'b1100, 4'hE, 5'b00000, 1'b1, 1'b1, 4,
                    {S_FETCH, S_FETCH2, S_DECODE, S_JUMP, 8'h0});
      applyStimulus("jnever", 4'b0100, 4'b1100, 4'h4, 5'b11111, 1'b1, 1'b0, 4,
                    {S_FETCH, S_FETCH2, S_DECODE, S_JUMP, 8'h0});
      applyStimulus("bne",    4'b1100, 4'b0000, 4'h1, 5'b00000, 1'b1, 1'b1, 4,
                    {S_FETCH, S_FETCH2, S_DECODE, S_BRANCH, 8'h0});
      applyStimulus("blt",    4'b1100, 4'b0000, 4'hC, 5'b00010, 1'b1, 1'b1, 4,
                    {S_FETCH, S_FETCH2, S_DECODE, S_BRANCH, 8'h0});
      applyStimulus("bgeN",   4'b1100, 4'b0000, 4'hD, 5'b00010, 1'b1, 1'b0, 4,
                    {S_FETCH, S_FETCH2, S_DECODE, S_BRANCH, 8'h0});
      applyStimulus("nop",    4'b1111, 4'b0000, 4'h0, 5'b00000, 1'b1, 1'b0, 3,
                    {S_FETCH, S_FETCH2, S_DECODE, 12'h0});
      applyStimulus("nopx",   4'b0100, 4'b0010, 4'h0, 5'b00000, 1'b1, 1'b0, 3,
                    {S_FETCH, S_FETCH2, S_DECODE, 12'h0});

      // Abort a load while it sits in LD_CAP
      regWrSeen = 1'b0;
      applyStimulus("ldabort", 4'b0100, 4'b0000, 4'h3, 5'b00000, 1'b1, 1'b0, 5,
                    {S_FETCH, S_FETCH2, S_DECODE, S_LD_ADDR, S_LD_CAP, 4'h0});
      #2 reset = 1'b0;
      #1;
      e.tag = "ldabort.async"; e.val = {S_FETCH, expOuts(S_FETCH, 4'h0, 1'b0)};
      sbQ.push_back(e);
      checkOutput();
      compared++;
      assert (regWrSeen === 1'b0) else begin
         mismatched++;
         $error("[TB] FAIL ldabort.regwr: observed=%b expected=0", regWrSeen);
      end
      @(posedge clk);
      #2 reset = 1'b1;
      applyStimulus("addPost", 4'b0000, 4'b0101, 4'h1, 5'b00000, 1'b1, 1'b0, 5,
                    {S_FETCH, S_FETCH2, S_DECODE, S_EXEC, S_ALU_WB, 4'h0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter OPL, 4, width of opcode, opcode-extension and condition fields.
REQ-002 SHALL have parameter PSRL, 5, width of processor status flags.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports OP_CODE, OP_EXT, Rdest_addr  in  OPL each  decoded instruction fields (Rdest_addr doubles as condition code).
REQ-006 SHALL have port PSR_OUT  in  PSRL  flags: [0]=C, [1]=L, [2]=F, [3]=Z, [4]=N.
REQ-007 SHALL have ports PC_S, MEM_S  out  1  mux selects (PC_S 1=ALU result, 0=Rsrc; MEM_S 1=PC, 0=Rsrc).
REQ-008 SHALL have ports WD_S, ALUA_S, ALUB_S  out  2 each  (WD 00 imm/01 Rsrc/10 memdata/11 ALUout; A 00 Rsrc/01 PC/10 imm; B 00 Rdest/01 imm/10 one).
REQ-009 SHALL have ports INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN, SE_SIGN, REG_WR, MEM_WE  out  1 each.
REQ-010 SHALL have port state_dbg  out  4  current state encoding.

Function
REQ-011 SHALL be Moore: all outputs decoded from current state only, except SE_SIGN (combinational from OP_CODE) and the taken/not-taken term in BRANCH/JUMP.
REQ-012 States: FETCH, FETCH2, DECODE, EXEC, ALU_WB, MOV, MOVI, LD_ADDR, LD_CAP, LD_WB, STORE, BRANCH, JUMP.
REQ-013 FETCH: MEM_S=1, all enables 0; always -> FETCH2.
REQ-014 FETCH2: MEM_S=1, INSTR_EN=1, PC_EN=1, PC_S=1, ALUA_S=01, ALUB_S=10 (PC+1); -> DECODE.
REQ-015 DECODE: all enables 0 (regfile read registers Rsrc/Rdest); next state by OP_CODE/OP_EXT per REQ-016.
REQ-016 Decode: 0000 ext 1101 -> MOV; other 0000 -> EXEC; 0100 ext 0000 -> LD_ADDR; 0100 ext 0100 -> STORE; 0100 ext 1100 -> JUMP; other 0100 -> FETCH (NOP); 1100 -> BRANCH; 1101 -> MOVI; 1111 -> FETCH (NOP); all others -> EXEC.
REQ-017 EXEC: ALU_OUT_EN=1, PSR_EN=1; R-type ALUA_S=00, ALUB_S=00; immediate ALUA_S=10, ALUB_S=00; CMP (0000/1011) and CMPI (1011) -> FETCH, else -> ALU_WB.
REQ-018 ALU_WB: WD_S=11, REG_WR=1; -> FETCH.
REQ-019 MOV: WD_S=01, REG_WR=1; MOVI: WD_S=00, REG_WR=1; both -> FETCH.
REQ-020 LD_ADDR: MEM_S=0 -> LD_CAP: MEM_S=0, MEM_REG_EN=1 -> LD_WB: WD_S=10, REG_WR=1 -> FETCH.
REQ-021 STORE: MEM_S=0, MEM_WE=1 for exactly one cycle; -> FETCH.
REQ-022 BRANCH: if condition true, PC_EN=1, PC_S=1, ALUA_S=01, ALUB_S=01 (PC+1+sext(imm)); else no enable; -> FETCH.
REQ-023 JUMP: if condition true, PC_EN=1, PC_S=0; -> FETCH.
REQ-024 Conditions: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0110 GT N; 0111 LE !N; 1100 LT L; 1101 GE !L; 1110 UC 1; all others never taken.
REQ-025 SE_SIGN SHALL be 0 for OP_CODE 0001, 0010, 0011, 1101; 1 otherwise.
REQ-026 PC_EN SHALL never coincide with PSR_EN, ALU_OUT_EN or REG_WR (datapath forces ADD when PC_EN).
REQ-027 Cycle counts: R/immediate ALU 5; CMP/CMPI, MOV, MOVI, store, branch, jump 4; load 6; NOP 3.
REQ-028 MEM_WE and REG_WR SHALL never both be 1.

Reset
REQ-029 reset low SHALL force state FETCH immediately, independent of clk; outputs then MEM_S=1, all others 0.
REQ-030 Reset mid-instruction SHALL abort it; no write (REG_WR, MEM_WE, PC_EN) occurs in the cycle reset is released; first edge after release -> FETCH2.

Structure
REQ-031 State encodings, opcode/extension constants and condition codes SHALL live in shared package control_pkg.
REQ-032 Condition evaluation SHALL be one combinational sub-module cond_eval (cond, flags -> taken).

Verification
REQ-033 Reset released, memory holds ADD r1,r2 -> states FETCH,FETCH2,DECODE,EXEC,ALU_WB; REG_WR=1 only in cycle 5, WD_S=11.
REQ-034 LOAD r3,[r4] -> MEM_S=0 in LD_ADDR/LD_CAP, MEM_REG_EN in cycle 5, REG_WR with WD_S=10 in cycle 6.
REQ-035 BEQ +4 with PSR_OUT=5'b01000 -> PC_EN=1, ALUB_S=01 in cycle 4; repeat with PSR_OUT=0 -> PC_EN=0.
REQ-036 CMPI then STORE -> CMPI: PSR_EN=1, no REG_WR, 4 cycles; STORE: MEM_WE=1 exactly one cycle.
REQ-037 Assert reset during LD_CAP -> state_dbg=FETCH asynchronously, no REG_WR ever issued for that load.
REQ-038 Opcode 1111 -> FETCH,FETCH2,DECODE,FETCH with no write enables.
